ad5628_scan_seq: RTL

Parametrised successor to the fixed AD5628 config + square-wave path. On `start`, writes NUM_CH DAC channel values from an internal register file to the AD5628 over SPI. It then enters a run phase: drives a programmable square wave and scans an analogue mux select bus (generalised A0/A1) through 2^SEL_W channels. Sits between the system clock domain and the AD5628/DG636-class mux pins at top level.

---
 rtl/ad5628_scan_seq.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/ad5628_scan_seq.sv
// AD5628 configuration sequencer: writes NUM_CH channel frames over SPI, then scans a mux
// select bus while driving a square wave. Define AD5628_SCAN_INTREF_EN to prepend an internal-reference frame.
module ad5628_scan_seq #(
   parameter int CLK_DIV = 2,
   parameter int NUM_CH  = 8,
   parameter int DATA_W  = 12,
   parameter int SQ_HALF = 25,
   parameter int SEL_W   = 2,
   parameter int DWELL   = 4
) (
   input  logic              clk_sys_i,
   input  logic              rst_sys_i,
   input  logic              cfg_we_i,
   input  logic [2:0]        cfg_ch_i,
   input  logic [DATA_W-1:0] cfg_data_i,
   input  logic              start_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              sclk_o,
   output logic              mosi_o,
   output logic              cs_o,
   output logic [SEL_W-1:0]  sel_o,
   output logic              sq_wave_o
);
   localparam int DIV_W = $clog2(2*CLK_DIV);
   localparam int SQ_W  = $clog2(SQ_HALF+1);
   localparam int PER_W = $clog2(DWELL+1);

`ifdef AD5628_SCAN_INTREF_EN
   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SHIFT, S_GAP, S_RUN, S_REF} state_t;
`else
   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SHIFT, S_GAP, S_RUN} state_t;
`endif

   state_t            state_q, state_d;
   logic [2:0]        ch_q, ch_d;
   logic [DIV_W-1:0]  div_q, div_d;
   logic [5:0]        half_q, half_d;
   logic [31:0]       shreg_q, shreg_d;
   logic [SQ_W-1:0]   sq_cnt_q, sq_cnt_d;
   logic              sq_q, sq_d;
   logic [PER_W-1:0]  per_q, per_d;
   logic [SEL_W-1:0]  sel_q, sel_d;
   logic              done_q, done_d;
   logic [DATA_W-1:0] regs_q [8];
   logic [11:0]       data12;
   logic [31:0]       frame_word;
`ifdef AD5628_SCAN_INTREF_EN
   logic              ref_q, ref_d;
`endif

   // Narrow channel values are left-aligned into the 12-bit DAC field.
   assign data12     = 12'(regs_q[ch_q]) << (12 - DATA_W);
   assign frame_word = {4'h0, 4'h3, {1'b0, ch_q}, data12, 8'h00};

   always_comb begin
      state_d  = state_q;
      ch_d     = ch_q;
      div_d    = div_q;
      half_d   = half_q;
      shreg_d  = shreg_q;
`ifdef AD5628_SCAN_INTREF_EN
      ref_d    = ref_q;
`endif
      unique case (state_q)
         S_IDLE, S_RUN: begin
            if (start_i) begin
               ch_d   = '0;
               div_d  = '0;
               half_d = '0;
`ifdef AD5628_SCAN_INTREF_EN
               state_d = S_REF;
`else
               state_d = S_LOAD;
`endif
            end
         end
`ifdef AD5628_SCAN_INTREF_EN
         S_REF: begin
            shreg_d = 32'h0800_0001;
            ref_d   = 1'b1;
            state_d = S_SHIFT;
         end
`endif
         S_LOAD: begin
            shreg_d = frame_word;
            state_d = S_SHIFT;
         end
         S_SHIFT: begin
            if (div_q == DIV_W'(CLK_DIV-1)) begin
               div_d = '0;
               if (half_q == 6'd63) begin
                  state_d = S_GAP;
               end else begin
                  half_d = half_q + 6'd1;
                  // leaving a low half-period means SCLK rises: present next bit
                  if (half_q[0]) shreg_d = {shreg_q[30:0], 1'b0};
               end
            end else begin
               div_d = div_q + DIV_W'(1);
            end
         end
         S_GAP: begin
            if (div_q == DIV_W'(2*CLK_DIV-2)) begin
               div_d  = '0;
               half_d = '0;
`ifdef AD5628_SCAN_INTREF_EN
               if (ref_q) begin
                  ref_d   = 1'b0;
                  state_d = S_LOAD;
               end else
`endif
               if (ch_q < 3'(NUM_CH-1)) begin
                  ch_d    = ch_q + 3'd1;
                  state_d = S_LOAD;
               end else begin
                  state_d = S_RUN;
               end
            end else begin
               div_d = div_q + DIV_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      sq_cnt_d = '0;
      sq_d     = 1'b0;
      per_d    = '0;
      sel_d    = '0;
      done_d   = (state_d == S_RUN) && (state_q != S_RUN);
      // Scan state only advances while staying in RUN; entry and restart clear it.
      if (state_q == S_RUN && state_d == S_RUN) begin
         sq_cnt_d = sq_cnt_q;
         sq_d     = sq_q;
         per_d    = per_q;
         sel_d    = sel_q;
         if (sq_cnt_q == SQ_W'(SQ_HALF-1)) begin
            sq_cnt_d = '0;
            sq_d     = ~sq_q;
            if (!sq_q) begin
               per_d = per_q + PER_W'(1);
            end else if (per_q == PER_W'(DWELL)) begin
               per_d = '0;
               sel_d = sel_q + SEL_W'(1);
            end
         end else begin
            sq_cnt_d = sq_cnt_q + SQ_W'(1);
         end
      end
   end

   always_ff @(posedge clk_sys_i) begin
      if (rst_sys_i) begin
         state_q  <= S_IDLE;
         ch_q     <= '0;
         div_q    <= '0;
         half_q   <= '0;
         shreg_q  <= '0;
         sq_cnt_q <= '0;
         sq_q     <= 1'b0;
         per_q    <= '0;
         sel_q    <= '0;
         done_q   <= 1'b0;
         regs_q   <= '{default: '0};
`ifdef AD5628_SCAN_INTREF_EN
         ref_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         ch_q     <= ch_d;
         div_q    <= div_d;
         half_q   <= half_d;
         shreg_q  <= shreg_d;
         sq_cnt_q <= sq_cnt_d;
         sq_q     <= sq_d;
         per_q    <= per_d;
         sel_q    <= sel_d;
         done_q   <= done_d;
`ifdef AD5628_SCAN_INTREF_EN
         ref_q    <= ref_d;
`endif
         if (cfg_we_i && ({1'b0, cfg_ch_i} < 4'(NUM_CH))) regs_q[cfg_ch_i] <= cfg_data_i;
      end
   end

   assign busy_o    = (state_q != S_IDLE) && (state_q != S_RUN);
   assign done_o    = done_q;
   assign cs_o      = (state_q != S_SHIFT);
   assign sclk_o    = (state_q != S_SHIFT) || !half_q[0];
   assign mosi_o    = (state_q == S_SHIFT) && shreg_q[31];
   assign sel_o     = sel_q;
   assign sq_wave_o = sq_q;

endmodule
